// File: rtl/button_event_queue_if.sv
// Event stream interface between the button queue and the game controller.
// master: evt_valid/evt_id/evt_count out, evt_ready in; slave: the reverse.
interface button_event_queue_if #(
   parameter int N_BTN = 4,
   parameter int DEPTH = 4
);
   localparam int IDW = $clog2(N_BTN);
   localparam int CW  = $clog2(DEPTH) + 1;

   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic           evt_ready;
   logic [CW-1:0]  evt_count;

   modport master (
      output evt_valid,
      output evt_id,
      output evt_count,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      input  evt_count,
      output evt_ready
   );
endinterface

// File: rtl/button_event_queue.sv
// Serialises per-button release pulses into an ordered event FIFO through a
// round-robin arbiter over registered pending bits.
// Ports: clk, reset_n (async active-low), btn_pulse[N_BTN], evt (master:
// evt_valid, evt_id, evt_ready, evt_count), ovf_cnt[8].
// Macro BTN_QUEUE_OVF_CNT_EN: enables the saturating lost-event counter;
// when undefined ovf_cnt is tied to zero.
module button_event_queue #(
   parameter int N_BTN = 4,
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [N_BTN-1:0]            btn_pulse,
   button_event_queue_if.master        evt,
   output logic [7:0]                  ovf_cnt
);
   localparam int IDW = $clog2(N_BTN);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam int AW  = $clog2(DEPTH);

   logic [N_BTN-1:0] pending_q, pending_d;
   logic [IDW-1:0]   last_grant_q, last_grant_d;
   logic [IDW-1:0]   mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             push, pop, found;
   logic [IDW-1:0]   win_id;
   logic [N_BTN-1:0] grant_vec;

   assign evt.evt_valid = (cnt_q != '0);
   assign evt.evt_id    = (cnt_q != '0) ? mem_q[rd_q] : '0;
   assign evt.evt_count = cnt_q;

   assign pop  = (cnt_q != '0) && evt.evt_ready;
   assign push = (pending_q != '0) &&
                 ((cnt_q < CW'(DEPTH)) || pop);

   // Search begins one past the last winner so every button gets a turn.
   always_comb begin
      int ix;
      ix     = 0;
      found  = 1'b0;
      win_id = '0;
      for (int k = 1; k <= N_BTN; k++) begin
         ix = (int'(last_grant_q) + k) % N_BTN;
         if (!found && pending_q[ix]) begin
            found  = 1'b1;
            win_id = IDW'(ix);
         end
      end
   end

   always_comb begin
      grant_vec = '0;
      if (push) grant_vec[win_id] = 1'b1;
   end

   // A pulse on the granted button re-arms it rather than being dropped.
   assign pending_d    = (pending_q & ~grant_vec) | btn_pulse;
   assign last_grant_d = push ? win_id : last_grant_q;
   assign cnt_d        = cnt_q + CW'(push) - CW'(pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pending_q    <= '0;
         last_grant_q <= IDW'(N_BTN - 1);
         wr_q         <= '0;
         rd_q         <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         if (push) begin
            mem_q[wr_q] <= win_id;
            wr_q        <= wr_q + 1'b1;
         end
         if (pop) rd_q <= rd_q + 1'b1;
      end
   end

`ifdef BTN_QUEUE_OVF_CNT_EN
   logic [N_BTN-1:0] lost;
   logic [3:0]       lost_n;
   logic [8:0]       ovf_sum;
   logic [7:0]       ovf_q, ovf_d;

   // Lost: new pulse while the same button is still waiting and not granted.
   assign lost = btn_pulse & pending_q & ~grant_vec;

   always_comb begin
      lost_n = '0;
      for (int i = 0; i < N_BTN; i++) lost_n = lost_n + 4'(lost[i]);
   end

   assign ovf_sum = {1'b0, ovf_q} + {5'd0, lost_n};
   assign ovf_d   = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) ovf_q <= '0;
      else          ovf_q <= ovf_d;
   end

   assign ovf_cnt = ovf_q;
`else
   assign ovf_cnt = 8'd0;
`endif
endmodule

// File: tb/tb_button_event_queue.sv
// Randomised and directed bench for button_event_queue against a
// queue-based reference model.
module tb_button_event_queue;
   localparam int N = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [N-1:0] btn_pulse = '0;
   logic [7:0]   ovf_cnt;

   button_event_queue_if #(.N_BTN(N), .DEPTH(D)) evt_if ();

   button_event_queue #(.N_BTN(N), .DEPTH(D)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_pulse (btn_pulse),
      .evt       (evt_if),
      .ovf_cnt   (ovf_cnt)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   bit [N-1:0] m_pend;
   int         m_q[$];
   int         m_lg;
   int         m_ovf;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp,
                  $time);
      end
   endtask

   function automatic int exp_ovf();
`ifdef BTN_QUEUE_OVF_CNT_EN
      return m_ovf;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_pend = '0;
      m_q.delete();
      m_lg  = N - 1;
      m_ovf = 0;
   endtask

   task automatic check_outputs();
      int hd;
      hd = (m_q.size() > 0) ? m_q[0] : 0;
      check("evt_valid", int'(evt_if.evt_valid), int'(m_q.size() > 0));
      check("evt_id", int'(evt_if.evt_id), hd);
      check("evt_count", int'(evt_if.evt_count), m_q.size());
      check("ovf_cnt", int'(ovf_cnt), exp_ovf());
   endtask

   task automatic model_step(input bit [N-1:0] p, input bit r);
      bit pop, push;
      int win, lost;
      pop  = (m_q.size() > 0) && r;
      push = (m_pend != 0) && ((m_q.size() < D) || pop);
      win  = -1;
      if (push) begin
         for (int k = 1; k <= N; k++) begin
            int ix;
            ix = (m_lg + k) % N;
            if (win < 0 && m_pend[ix]) win = ix;
         end
      end
      lost = 0;
      for (int i = 0; i < N; i++)
         if (p[i] && m_pend[i] && !(push && win == i)) lost++;
      if (push) m_pend[win] = 1'b0;
      m_pend = m_pend | p;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         m_q.push_back(win);
         m_lg = win;
      end
      m_ovf = (m_ovf + lost > 255) ? 255 : m_ovf + lost;
   endtask

   // Called at a negedge: check, drive, advance model, move to next negedge.
   task automatic cycle(input bit [N-1:0] p, input bit r);
      check_outputs();
      btn_pulse       = p;
      evt_if.evt_ready = r;
      model_step(p, r);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cycle('0, r);
   endtask

   initial begin
      evt_if.evt_ready = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      reset_n = 1'b1;
      @(negedge clk);

      // Single pulse on button 2
      cycle(4'b0100, 1'b1);
      cycle(4'b0000, 1'b1);
      check("single_id", int'(evt_if.evt_id), 2);
      check("single_vld", int'(evt_if.evt_valid), 1);
      idle(3, 1'b1);

      // All buttons at once
      cycle(4'b1111, 1'b1);
      idle(6, 1'b1);

      // Round-robin after id 1
      cycle(4'b0010, 1'b1);
      idle(3, 1'b1);
      cycle(4'b0101, 1'b1);
      idle(5, 1'b1);

      // Backpressure, full FIFO, lost event
      cycle(4'b1111, 1'b0);
      idle(5, 1'b0);
      cycle(4'b0100, 1'b0);
      idle(1, 1'b0);
      cycle(4'b0100, 1'b0);
      idle(1, 1'b0);
      check("bp_count", int'(evt_if.evt_count), 4);
`ifdef BTN_QUEUE_OVF_CNT_EN
      check("bp_ovf", int'(ovf_cnt), 1);
`else
      check("bp_ovf", int'(ovf_cnt), 0);
`endif
      idle(8, 1'b1);

      // Push and pop on a full FIFO
      cycle(4'b1111, 1'b0);
      idle(5, 1'b0);
      cycle(4'b0010, 1'b0);
      idle(2, 1'b0);
      cycle(4'b0000, 1'b1);
      check("full_pp_cnt", int'(evt_if.evt_count), 4);
      idle(8, 1'b1);

      // Reset with events queued
      cycle(4'b0111, 1'b0);
      idle(4, 1'b0);
      reset_n = 1'b0;
      #1;
      check("rst_valid", int'(evt_if.evt_valid), 0);
      check("rst_count", int'(evt_if.evt_count), 0);
      check("rst_ovf", int'(ovf_cnt), 0);
      model_reset();
      @(negedge clk);
      reset_n = 1'b1;
      cycle(4'b1000, 1'b1);
      cycle(4'b0000, 1'b1);
      check("post_rst_id", int'(evt_if.evt_id), 3);
      idle(3, 1'b1);

      // Random traffic with phases of heavy backpressure
      for (int i = 0; i < 600; i++) begin
         bit [N-1:0] p;
         bit         r;
         p = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         if ((i / 100) % 2 == 1) r = ($urandom_range(0, 5) == 0);
         else                   r = ($urandom_range(0, 3) != 0);
         cycle(p, r);
      end
      idle(12, 1'b1);
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/button_event_queue.md
# button_event_queue

Collects single-cycle release pulses from up to N_BTN debounced button channels and serialises them into an ordered event stream for the game control FSM. It sits between the per-button debounce/release-detect stages and the top-level controller, sharing one event interface among all buttons through a round-robin arbiter and a small FIFO. No press is lost while queue space exists, and press order is preserved across buttons.

## Interface
- N_BTN, 4, number of button channels (2..8)
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- IDW, $clog2(N_BTN), event id width (derived, not overridden)
- CW, $clog2(DEPTH)+1, occupancy width (derived)

- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- btn_pulse  input  N_BTN  one-cycle release pulses, bit i = button i
- evt_valid  output  1  FIFO head holds an event
- evt_id  output  IDW  button index of head event; 0 when evt_valid=0
- evt_ready  input  1  consumer accepts head when evt_valid & evt_ready
- evt_count  output  CW  FIFO occupancy, 0..DEPTH
- ovf_cnt  output  8  lost-event counter (see Configuration)

## Operation
- pending[N_BTN-1:0] register: bit i set on btn_pulse[i], cleared when button i is granted into the FIFO.
- Arbiter works on registered pending only, never on same-cycle btn_pulse.
- Push enable: pending≠0 and (evt_count<DEPTH or pop this cycle). At most one push per cycle.
- Round-robin: search starts at last_grant+1 modulo N_BTN; first set pending bit wins; last_grant updates to winner on push only.
- Pop: evt_valid & evt_ready removes head; pointers wrap modulo DEPTH.
- Simultaneous push and pop on full FIFO: both occur, evt_count stays DEPTH.
- Simultaneous push and pop on empty FIFO: not possible (push lands, evt_valid rises next cycle).
- btn_pulse[i] in same cycle pending[i] is granted: pending[i] stays set (new event, not lost).
- btn_pulse[i] while pending[i]=1 and not granted that cycle: event lost; ovf_cnt increments.
- Multiple lost events in one cycle (several bits): ovf_cnt increments by 1 per lost bit.
- evt_ready ignored while evt_valid=0.

## Timing
- Reset values: pending=0, FIFO empty, last_grant=N_BTN-1 (so button 0 searched first), evt_valid=0, evt_id=0, evt_count=0, ovf_cnt=0.
- Latency: pulse sampled at edge t sets pending; push at edge t+1; evt_valid=1 after edge t+1 (1 cycle after pulse is captured, 2 edges from pulse assertion).
- Outputs registered; evt_id and evt_valid change only on clock edges.
- Throughput: one event in and one out per cycle sustained.
- Reset mid-operation: all pending and queued events discarded immediately; outputs return to reset values asynchronously; first edge after reset_n rises behaves as post-reset cycle 0.

## Configuration
- BTN_QUEUE_OVF_CNT_EN defined: ovf_cnt is an 8-bit counter of lost events, saturating at 255, cleared only by reset.
- Not defined: counter logic absent, ovf_cnt tied to 8'd0; all other behaviour identical.

## Test plan
- Single pulse: btn_pulse=4'b0100 one cycle, evt_ready=1 -> evt_valid high for exactly one cycle with evt_id=2, 2 edges after pulse; evt_count returns to 0.
- Simultaneous: btn_pulse=4'b1111 one cycle, evt_ready=1 -> evt_id sequence 0,1,2,3 on consecutive cycles, no gaps.
- Round-robin: after id 1 granted, pending={0,2} set together -> order 2 then 0.
- Backpressure/full: evt_ready=0, pulse 4'b1111, then btn 2 pulse twice -> evt_count=4, pending[2]=1, ovf_cnt=1 (macro on) / 0 (macro off); raise evt_ready -> ids 0,1,2,3,2.
- Push+pop on full: FIFO full, pending[1]=1, evt_ready=1 one cycle -> head popped, id 1 pushed same edge, evt_count stays 4.
- Reset mid-queue: 3 events queued, reset_n low 1 cycle -> evt_valid=0, evt_count=0, ovf_cnt=0 immediately; fresh pulse on btn 3 -> evt_id=3 with normal latency.
